// File: rtl/ka_decode_dat_q.sv
// Queued KA data decoder: buffers KA words in an in-order queue and routes each head word
// to the short-key or long-key consumer by its selector. Reserved selectors are dropped and flagged.
module ka_decode_dat_q #(
  parameter int SELW   = 4,
  parameter int SLICES = 2,
  parameter int BADDR  = 8,
  parameter int DEPTH  = 4,
  localparam int W     = SELW + SLICES * BADDR,
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [W-1:0]    t_ka_dat,
  input  logic            t_ka_valid,
  output logic            t_ka_ready,
  output logic [W-1:0]    i_ka_dat,
  output logic [SELW-1:0] k_ctrl,
  output logic [SELW-1:0] i_k_sk_dat,
  output logic            i_k_sk_valid,
  input  logic            i_k_sk_ready,
  output logic [SELW-1:0] i_k_lk_dat,
  output logic            i_k_lk_valid,
  input  logic            i_k_lk_ready,
  output logic            drop_err,
  input  logic            err_clr,
  output logic [15:0]     sk_cnt,
  output logic [15:0]     lk_cnt,
  output logic [LW-1:0]   fifo_level
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]    mem_q [DEPTH];
  logic [PW-1:0]   wrPtr_q, wrPtr_d;
  logic [PW-1:0]   rdPtr_q, rdPtr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [15:0]     skCnt_q, skCnt_d;
  logic [15:0]     lkCnt_q, lkCnt_d;
  logic            dropErr_q, dropErr_d;

  logic            empty, full;
  logic [W-1:0]    headWord;
  logic [SELW-1:0] headSel;
  logic            reserved, route;
  logic            skFire, lkFire, push, pop;

  assign empty    = (level_q == '0);
  assign full     = (level_q == LW'(DEPTH));
  assign headWord = mem_q[rdPtr_q];
  assign headSel  = headWord[W-1 -: SELW];
  assign route    = headSel[SELW-1];
  // A reserved head needs no consumer: it leaves the queue on its own.
  assign reserved = !empty && (headSel == '1);

  assign t_ka_ready   = !full && !reset_n;
  assign i_k_sk_valid = !empty && !reserved && !route;
  assign i_k_lk_valid = !empty && !reserved && route;

  assign skFire = i_k_sk_valid && i_k_sk_ready;
  assign lkFire = i_k_lk_valid && i_k_lk_ready;
  assign push   = t_ka_valid && t_ka_ready;
  assign pop    = skFire || lkFire || reserved;

  assign i_ka_dat   = empty ? '0 : headWord;
  assign k_ctrl     = empty ? '0 : headSel;
  assign i_k_sk_dat = empty ? '0 : headSel;
  assign i_k_lk_dat = empty ? '0 : headSel;
  assign drop_err   = dropErr_q;
  assign sk_cnt     = skCnt_q;
  assign lk_cnt     = lkCnt_q;
  assign fifo_level = level_q;

  always_comb begin
    wrPtr_d = push ? wrPtr_q + PW'(1) : wrPtr_q;
    rdPtr_d = pop  ? rdPtr_q + PW'(1) : rdPtr_q;
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    skCnt_d = (skFire && skCnt_q != 16'hFFFF) ? skCnt_q + 16'd1 : skCnt_q;
    lkCnt_d = (lkFire && lkCnt_q != 16'hFFFF) ? lkCnt_q + 16'd1 : lkCnt_q;
    // Setting wins over clearing so a drop in the clearing cycle is not lost.
    dropErr_d = dropErr_q;
    if (reserved)     dropErr_d = 1'b1;
    else if (err_clr) dropErr_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      level_q   <= '0;
      skCnt_q   <= '0;
      lkCnt_q   <= '0;
      dropErr_q <= 1'b0;
    end else begin
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      level_q   <= level_d;
      skCnt_q   <= skCnt_d;
      lkCnt_q   <= lkCnt_d;
      dropErr_q <= dropErr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wrPtr_q] <= t_ka_dat;
  end

endmodule

// File: tb/tb_ka_decode_dat_q.sv
// Directed self-checking bench for ka_decode_dat_q (SELW=4, SLICES=2, BADDR=8, DEPTH=4).
module tb_ka_decode_dat_q;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [19:0] t_ka_dat;
  logic        t_ka_valid;
  logic        t_ka_ready;
  logic [19:0] i_ka_dat;
  logic [3:0]  k_ctrl;
  logic [3:0]  i_k_sk_dat;
  logic        i_k_sk_valid;
  logic        i_k_sk_ready;
  logic [3:0]  i_k_lk_dat;
  logic        i_k_lk_valid;
  logic        i_k_lk_ready;
  logic        drop_err;
  logic        err_clr;
  logic [15:0] sk_cnt;
  logic [15:0] lk_cnt;
  logic [2:0]  fifo_level;

  int errors = 0;
  int checks = 0;

  ka_decode_dat_q #(.SELW(4), .SLICES(2), .BADDR(8), .DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .t_ka_dat(t_ka_dat), .t_ka_valid(t_ka_valid), .t_ka_ready(t_ka_ready),
    .i_ka_dat(i_ka_dat), .k_ctrl(k_ctrl),
    .i_k_sk_dat(i_k_sk_dat), .i_k_sk_valid(i_k_sk_valid), .i_k_sk_ready(i_k_sk_ready),
    .i_k_lk_dat(i_k_lk_dat), .i_k_lk_valid(i_k_lk_valid), .i_k_lk_ready(i_k_lk_ready),
    .drop_err(drop_err), .err_clr(err_clr),
    .sk_cnt(sk_cnt), .lk_cnt(lk_cnt), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [19:0] dat,
                               input logic skRdy, input logic lkRdy, input logic clr);
    t_ka_valid   = valid;
    t_ka_dat     = dat;
    i_k_sk_ready = skRdy;
    i_k_lk_ready = lkRdy;
    err_clr      = clr;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    reset_n = 1'b1;
    applyStimulus(1'b0, 20'h0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    $display("[TB] reset state");
    checkOutput("rst_ready",  32'(t_ka_ready), 32'h0);
    checkOutput("rst_level",  32'(fifo_level), 32'h0);
    checkOutput("rst_skv",    32'(i_k_sk_valid), 32'h0);
    checkOutput("rst_lkv",    32'(i_k_lk_valid), 32'h0);
    checkOutput("rst_dat",    32'(i_ka_dat), 32'h0);
    checkOutput("rst_skcnt",  32'(sk_cnt), 32'h0);
    checkOutput("rst_drop",   32'(drop_err), 32'h0);
    reset_n = 1'b0;
    tick();
    checkOutput("post_rst_ready", 32'(t_ka_ready), 32'h1);

    $display("[TB] single sk word");
    applyStimulus(1'b1, 20'h51234, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 20'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("sk_valid",  32'(i_k_sk_valid), 32'h1);
    checkOutput("sk_dat",    32'(i_k_sk_dat), 32'h5);
    checkOutput("sk_ctrl",   32'(k_ctrl), 32'h5);
    checkOutput("sk_word",   32'(i_ka_dat), 32'h51234);
    checkOutput("sk_lkv",    32'(i_k_lk_valid), 32'h0);
    checkOutput("sk_level1", 32'(fifo_level), 32'h1);
    applyStimulus(1'b0, 20'h0, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 20'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("sk_level0", 32'(fifo_level), 32'h0);
    checkOutput("sk_cnt1",   32'(sk_cnt), 32'h1);
    checkOutput("empty_dat", 32'(i_ka_dat), 32'h0);
    checkOutput("empty_skv", 32'(i_k_sk_valid), 32'h0);

    $display("[TB] lk route");
    applyStimulus(1'b1, 20'hA00FF, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 20'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("lk_valid", 32'(i_k_lk_valid), 32'h1);
    checkOutput("lk_dat",   32'(i_k_lk_dat), 32'hA);
    checkOutput("lk_skv",   32'(i_k_sk_valid), 32'h0);
    applyStimulus(1'b0, 20'h0, 1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 20'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("lk_cnt1",    32'(lk_cnt), 32'h1);
    checkOutput("lk_skcnt_1", 32'(sk_cnt), 32'h1);

    $display("[TB] full and backpressure");
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 20'h10000 + 20'(i), 1'b0, 1'b0, 1'b0);
      tick();
    end
    checkOutput("full_level", 32'(fifo_level), 32'h4);
    checkOutput("full_ready", 32'(t_ka_ready), 32'h0);
    applyStimulus(1'b1, 20'h10005, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("full_held", 32'(fifo_level), 32'h4);
    applyStimulus(1'b1, 20'h10005, 1'b1, 1'b0, 1'b0);
    checkOutput("full_pop_ready", 32'(t_ka_ready), 32'h0);
    checkOutput("drain_h1", 32'(i_ka_dat), 32'h10001);
    tick();
    checkOutput("drain_h2",  32'(i_ka_dat), 32'h10002);
    checkOutput("drain_l3",  32'(fifo_level), 32'h3);
    checkOutput("drain_rdy", 32'(t_ka_ready), 32'h1);
    tick();
    applyStimulus(1'b0, 20'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("drain_h3",   32'(i_ka_dat), 32'h10003);
    checkOutput("drain_push", 32'(fifo_level), 32'h3);
    tick();
    checkOutput("drain_h4", 32'(i_ka_dat), 32'h10004);
    tick();
    checkOutput("drain_h5", 32'(i_ka_dat), 32'h10005);
    tick();
    applyStimulus(1'b0, 20'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("drain_empty", 32'(fifo_level), 32'h0);
    checkOutput("drain_cnt",   32'(sk_cnt), 32'h6);

    $display("[TB] reserved drop");
    applyStimulus(1'b1, 20'hF1111, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 20'h22222, 1'b0, 1'b0, 1'b0);
    checkOutput("rsv_skv",  32'(i_k_sk_valid), 32'h0);
    checkOutput("rsv_lkv",  32'(i_k_lk_valid), 32'h0);
    checkOutput("rsv_drop0", 32'(drop_err), 32'h0);
    tick();
    applyStimulus(1'b0, 20'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("rsv_drop1", 32'(drop_err), 32'h1);
    checkOutput("rsv_level", 32'(fifo_level), 32'h1);
    checkOutput("rsv_next",  32'(i_ka_dat), 32'h22222);
    checkOutput("rsv_nextv", 32'(i_k_sk_valid), 32'h1);
    tick();
    applyStimulus(1'b0, 20'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("rsv_cnt", 32'(sk_cnt), 32'h7);
    tick();
    applyStimulus(1'b1, 20'hF0000, 1'b0, 1'b0, 1'b0);
    checkOutput("rsv_clr", 32'(drop_err), 32'h0);
    tick();
    applyStimulus(1'b0, 20'h0, 1'b0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 20'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("rsv_set_wins", 32'(drop_err), 32'h1);
    checkOutput("rsv_level0",   32'(fifo_level), 32'h0);

    $display("[TB] reset mid-stream");
    applyStimulus(1'b1, 20'h33333, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 20'h44444, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 20'h55555, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 20'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("mid_level3", 32'(fifo_level), 32'h3);
    checkOutput("mid_cnt7",   32'(sk_cnt), 32'h7);
    reset_n = 1'b1;
    tick();
    checkOutput("mid_level0", 32'(fifo_level), 32'h0);
    checkOutput("mid_skv",    32'(i_k_sk_valid), 32'h0);
    checkOutput("mid_skcnt",  32'(sk_cnt), 32'h0);
    checkOutput("mid_lkcnt",  32'(lk_cnt), 32'h0);
    checkOutput("mid_drop",   32'(drop_err), 32'h0);
    checkOutput("mid_ready0", 32'(t_ka_ready), 32'h0);
    checkOutput("mid_dat",    32'(i_ka_dat), 32'h0);
    reset_n = 1'b0;
    #1;
    checkOutput("mid_ready1", 32'(t_ka_ready), 32'h1);
    tick();

    $display("[TB] streaming");
    applyStimulus(1'b1, 20'h60001, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 20'h60002, 1'b0, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 20'h60003 + 20'(i), 1'b1, 1'b0, 1'b0);
      tick();
      checkOutput($sformatf("stream_level%0d", i), 32'(fifo_level), 32'h2);
      checkOutput($sformatf("stream_head%0d", i), 32'(i_ka_dat), 32'h60002 + 32'(i));
    end
    applyStimulus(1'b0, 20'h0, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    applyStimulus(1'b0, 20'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("stream_empty", 32'(fifo_level), 32'h0);
    checkOutput("stream_cnt",   32'(sk_cnt), 32'h7);

    $display("[TB] head-of-line blocking");
    applyStimulus(1'b1, 20'h12345, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 20'h98765, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 20'h0, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("hol_lkv",   32'(i_k_lk_valid), 32'h0);
    checkOutput("hol_skv",   32'(i_k_sk_valid), 32'h1);
    checkOutput("hol_level", 32'(fifo_level), 32'h2);
    checkOutput("hol_lkcnt", 32'(lk_cnt), 32'h0);
    applyStimulus(1'b0, 20'h0, 1'b1, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 20'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("hol_head", 32'(i_ka_dat), 32'h98765);
    checkOutput("hol_lkv2", 32'(i_k_lk_valid), 32'h1);
    tick();
    applyStimulus(1'b0, 20'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("hol_lkcnt1", 32'(lk_cnt), 32'h1);
    checkOutput("hol_skcnt",  32'(sk_cnt), 32'h8);
    checkOutput("hol_empty",  32'(fifo_level), 32'h0);

    $display("[TB] counter saturation");
    applyStimulus(1'b1, 20'h00001, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 65540; i++) tick();
    checkOutput("sat_cnt", 32'(sk_cnt), 32'hFFFF);
    applyStimulus(1'b0, 20'h0, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 20'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("sat_hold",  32'(sk_cnt), 32'hFFFF);
    checkOutput("sat_empty", 32'(fifo_level), 32'h0);
    checkOutput("sat_lkcnt", 32'(lk_cnt), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ka_decode_dat_q.md
# ka_decode_dat_q

Buffered, parametrised successor to the single-cycle KA data decoder. It accepts KA words (selector field on top, SLICES×BADDR address field below) through a valid/ready handshake and holds them in a DEPTH-entry in-order queue. It decodes the head word's selector and routes the word to either the short-key (sk) or long-key (lk) consumer, each with its own handshake, instead of driving both unconditionally. It sits between the KA link and the key stores, and also provides reserved-selector drop detection and per-route statistics.

## Interface
- SELW, 4, selector width (top field of word)
- SLICES, 2, number of address slices
- BADDR, 8, bits per address slice
- DEPTH, 4, queue entries; power of two, ≥2
- W (derived), SELW+SLICES*BADDR, word width; LW = $clog2(DEPTH)+1

- clk  in  1  clock
- reset_n  in  1  reset; synchronous, active-high (asserted = 1)
- t_ka_dat  in  W  input word
- t_ka_valid  in  1  input word valid
- t_ka_ready  out  1  queue can accept
- i_ka_dat  out  W  full head word
- k_ctrl  out  SELW  head selector
- i_k_sk_dat  out  SELW  head selector, sk route
- i_k_sk_valid  out  1  head routed to sk
- i_k_sk_ready  in  1  sk consumer ready
- i_k_lk_dat  out  SELW  head selector, lk route
- i_k_lk_valid  out  1  head routed to lk
- i_k_lk_ready  in  1  lk consumer ready
- drop_err  out  1  sticky reserved-selector flag
- err_clr  in  1  clears drop_err
- sk_cnt, lk_cnt  out  16 each  saturating delivered-word counts
- fifo_level  out  LW  entries held

## Operation
- Field split: sel = word[W-1 -: SELW]; slice s = word[s*BADDR +: BADDR]. i_ka_dat carries the whole word unmodified.
- Push occurs when t_ka_valid && t_ka_ready. t_ka_ready = !full && !reset_n.
- Head decode uses the oldest entry:
  - reserved = (sel == all ones);
  - route = sel[SELW-1].
- Routing:
  - i_k_sk_valid = !empty && !reserved && route==0;
  - i_k_lk_valid = !empty && !reserved && route==1;
  - never both.
- Pop occurs on (sk_valid && sk_ready) or (lk_valid && lk_ready). A reserved head pops unconditionally in the cycle it is at the head, and sets drop_err.
- No bypass: head-of-line blocking is intended, and order is strictly preserved.
- Data outputs (i_ka_dat, k_ctrl, i_k_sk_dat, i_k_lk_dat) equal the head word/selector when not empty, and are 0 when empty.
- Counters:
  - sk_cnt increments on each sk handshake; lk_cnt increments on each lk handshake.
  - Both saturate at 0xFFFF. Dropped words are not counted.
- drop_err: set beats clear when a reserved pop and err_clr occur in the same cycle.
- fifo_level: +1 on push only, −1 on pop only, unchanged on simultaneous push and pop.

## Timing
- Reset (reset_n=1 at a clk edge) sets the following; storage contents are don't-care:
  - pointers = 0, fifo_level = 0;
  - sk_cnt = lk_cnt = 0, drop_err = 0;
  - all valids = 0, data outputs = 0, t_ka_ready = 0 while reset is held.
- Reset mid-operation discards all queued words at that edge. No partial handshake survives.
- Latency: a word pushed at edge N is visible at the head (valid/data) after edge N. This holds even when the queue is empty (no fall-through).
- Throughput: 1 word/cycle sustained when the consumer is ready.
- Full (level = DEPTH): t_ka_ready = 0. A pop in that cycle raises ready only after the next edge.
- Empty with a simultaneous push: no pop is possible that cycle.
- Pointer wrap at DEPTH is modulo; level distinguishes full from empty.
- Outputs other than the counters and drop_err are combinational from registered state.

## Test plan
Configuration for all scenarios: SELW=4, SLICES=2, BADDR=8, W=20, DEPTH=4.
- Single sk word: after reset, push 0x51234. Next cycle: i_k_sk_valid=1, i_k_sk_dat=0x5, k_ctrl=0x5, i_ka_dat=0x51234, i_k_lk_valid=0. Assert sk_ready → level 0, sk_cnt=1.
- lk route: push 0xA00FF → i_k_lk_valid=1, i_k_lk_dat=0xA, sk_valid=0. On lk handshake, lk_cnt=1 and sk_cnt is unchanged.
- Full/backpressure: both readies low, push 0x10001..0x10005. Expect:
  - level=4 and t_ka_ready=0 after the 4th push; the 5th is held.
  - Releasing sk_ready drains 0x10001..0x10004 in order, then 0x10005 is accepted.
- Reserved drop: push 0xF1111 then 0x22222.
  - 0xF1111 pops with no valid; drop_err=1.
  - 0x22222 is delivered on the next cycle.
  - err_clr → drop_err=0. A reserved pop coinciding with err_clr leaves drop_err=1.
- Reset mid-stream: level=3, sk_cnt=7, assert reset_n one cycle → level=0, all valids 0, counts 0, t_ka_ready=0 during reset and 1 after.
- Streaming and head-of-line blocking:
  - Continuous push and pop at level 2 keeps level at 2.
  - A sk head with sk_ready=0 blocks a queued lk word even with lk_ready=1.
  - sk_cnt preset near 0xFFFF saturates and does not wrap.
